echo_ctrl: RTL and testbench
============================

ECHO_CTRL -- requirements
Module: echo_ctrl

Interface
REQ-001 Parameter: ADDR_W, 13, delay-line RAM address width (depth 2^ADDR_W samples).
REQ-002 sysclk  in  1  sole clock; all logic on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 data_valid  in  1  ADC sample strobe, level signal, synchronous to sysclk.
REQ-005 enable  in  1  1 = echo running, 0 = return to IDLE.
REQ-006 delay_len  in  ADDR_W  echo delay in samples; 0 treated as 1.
REQ-007 clr_ovr  in  1  clears overrun flag.
REQ-008 ram_re  out  1  one-cycle read strobe to delay-line RAM (read latency 1).
REQ-009 ram_rdaddr  out  ADDR_W  read address, valid while ram_re=1.
REQ-010 ram_we  out  1  one-cycle write strobe for datapath sum y.
REQ-011 ram_wraddr  out  ADDR_W  write address, valid while ram_we=1.
REQ-012 fb_load  out  1  datapath registers RAM q into shift/halve stage.
REQ-013 fb_mute  out  1  1 = datapath forces feedback term to 0.
REQ-014 dac_strobe  out  1  one-cycle pulse, datapath registers DAC output.
REQ-015 state  out  2  current state encoding.
REQ-016 overrun  out  1  sticky: sample tick arrived while sequence busy.

Function
REQ-017 Tick = rising edge of data_valid, detected by one register; tick asserted the cycle after the edge is sampled.
REQ-018 States: IDLE=0, FILL=1, RUN=2; encoding 3 unused, decodes to IDLE next cycle.
REQ-019 IDLE: no strobes issued; enable=1 -> FILL, latching delay_len (0 -> 1) into dly_q and clearing fill_cnt.
REQ-020 Per accepted tick at cycle T, a 4-cycle sequence runs in every non-IDLE state: T+1 ram_re, T+2 fb_load, T+3 ram_we, T+4 dac_strobe; sequencer busy for T+1..T+4.
REQ-021 ram_rdaddr = (wr_ptr - dly_q) mod 2^ADDR_W; ram_wraddr = wr_ptr; wr_ptr increments (wrapping 2^ADDR_W-1 -> 0) on the cycle after ram_we.
REQ-022 fb_mute = 1 in IDLE and FILL, 0 in RUN; fb_mute sampled at T+1 held constant for the whole sequence.
REQ-023 FILL: fill_cnt increments per ram_we; at the ram_we where fill_cnt = dly_q-1, next state RUN.
REQ-024 RUN: delay_len (clamped) != dly_q -> FILL next cycle, relatch dly_q, clear fill_cnt, wr_ptr kept; an in-flight sequence completes with its original fb_mute.
REQ-025 enable=0 in FILL or RUN -> IDLE after any in-flight sequence finishes (after dac_strobe); enable takes priority over a delay change.
REQ-026 Tick while busy: dropped, no strobes, overrun set next cycle; clr_ovr clears it; simultaneous set and clear -> set wins.
REQ-027 Ticks with exactly 4 idle cycles between them (tick at T+5) accepted without overrun.

Reset
REQ-028 On rst: state IDLE, wr_ptr 0, fill_cnt 0, dly_q 1, sequencer idle, all strobes 0, fb_mute 1, overrun 0.
REQ-029 Edge-detect register resets to 1, so data_valid high at reset release yields no tick.
REQ-030 rst mid-sequence aborts it immediately; no partial strobe after rst asserts.

Structure
REQ-031 Package echo_pkg: state encoding constants, ADDR_W default, sequence phase offsets (RD=1, LD=2, WR=3, OUT=4).
REQ-032 One sub-module: the existing pulse_gen for tick detection, given an added reset; all else in echo_ctrl.

Verification
REQ-033 delay_len=3, enable=1, 5 ticks 10 cycles apart -> fb_mute=1 for ticks 1-3, 0 for 4-5; ram_wraddr 0..4; tick 4 ram_rdaddr=0.
REQ-034 wr_ptr=8191, delay_len=2, RUN -> ram_rdaddr=8189, ram_wraddr=8191, next write addr 0, next read 8190.
REQ-035 Ticks at cycles 0 and 3 -> second dropped, overrun=1; clr_ovr pulse -> 0; ticks 5 cycles apart -> no overrun.
REQ-036 RUN, delay_len 3 -> 5 -> FILL, fb_mute=1 for next 5 writes, then RUN; wr_ptr continuous.
REQ-037 rst asserted at T+2 of a sequence -> no ram_we/dac_strobe, all outputs at reset values, data_valid held high at release -> no tick.
REQ-038 delay_len=0 -> read address = wr_ptr-1, FILL lasts 1 write.

Source files
------------

// File: rtl/echo_pkg.sv
// echo_pkg -- shared definitions for the echo delay-line controller.
//   state_t    : controller state encoding (IDLE=0, FILL=1, RUN=2, 3 unused)
//   ADDR_W_DEF : default delay-line RAM address width
//   PH_*       : cycle offsets of each strobe after an accepted sample tick
package echo_pkg;

  localparam int ADDR_W_DEF = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Strobe offsets relative to the tick cycle T
  localparam int PH_RD  = 1;  // ram_re
  localparam int PH_LD  = 2;  // fb_load
  localparam int PH_WR  = 3;  // ram_we
  localparam int PH_OUT = 4;  // dac_strobe

endpackage

// File: rtl/echo_ctrl_pulse_gen.sv
// pulse_gen -- rising-edge detector for the ADC sample strobe.
//   sysclk : clock
//   rst    : asynchronous active-high reset
//   din    : level input (synchronous to sysclk)
//   pulse  : high for the one cycle in which din is high and was low last cycle
// The history register resets to 1 so that a level already high when reset
// is released is not mistaken for a fresh edge.
module pulse_gen (
  input  logic sysclk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic din_q;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) din_q <= 1'b1;
    else     din_q <= din;
  end

  assign pulse = din & ~din_q;

endmodule

// File: rtl/echo_ctrl.sv
// echo_ctrl -- control sequencer for a single-tap echo delay line.
// For every accepted sample tick it issues read, feedback-load, write and DAC
// strobes on four consecutive cycles, and tracks the circular write pointer.
// FILL mutes feedback until dly_q fresh samples are in the line; RUN feeds back.
//   sysclk      : clock
//   rst         : asynchronous active-high reset
//   data_valid  : ADC sample strobe (level)
//   enable      : 1 = echo running, 0 = return to IDLE
//   delay_len   : echo delay in samples (0 treated as 1)
//   clr_ovr     : clears the sticky overrun flag
//   ram_re/ram_rdaddr, ram_we/ram_wraddr : delay-line RAM strobes and addresses
//   fb_load     : datapath captures RAM read data
//   fb_mute     : datapath forces the feedback term to zero
//   dac_strobe  : datapath registers the DAC output
//   state       : current state encoding
//   overrun     : sticky, a tick arrived while a sequence was in flight
module echo_ctrl
  import echo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              data_valid,
  input  logic              enable,
  input  logic [ADDR_W-1:0] delay_len,
  input  logic              clr_ovr,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_rdaddr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic              fb_load,
  output logic              fb_mute,
  output logic              dac_strobe,
  output logic [1:0]        state,
  output logic              overrun
);

  state_t              state_q, state_d;
  logic                relatch;
  logic                tick, busy, accept, drop, fill_done;
  logic [PH_OUT:PH_RD] seq_p;   // bit n high on cycle T+n of a sequence
  logic                mute_q;
  logic [ADDR_W-1:0]   wr_ptr, fill_cnt, dly_q, dly_clamp;
  logic                ovr_q;

  pulse_gen u_pulse_gen (
    .sysclk (sysclk),
    .rst    (rst),
    .din    (data_valid),
    .pulse  (tick)
  );

  assign dly_clamp = (delay_len == '0) ? {{(ADDR_W-1){1'b0}}, 1'b1} : delay_len;
  assign busy      = |seq_p;
  // A tick is only taken while enabled, since a disable pending on an idle
  // sequencer drops to IDLE on the next edge.
  assign accept    = tick & enable & ~busy &
                     ((state_q == ST_FILL) | (state_q == ST_RUN));
  assign drop      = tick & busy;
  // Only writes issued while filling count toward the fill; a muted-off write
  // still in flight from RUN when the delay changes does not.
  assign fill_done = seq_p[PH_WR] & mute_q & (fill_cnt == dly_q - 1'b1);

  always_comb begin
    state_d = state_q;
    relatch = 1'b0;
    fb_mute = busy ? mute_q : (state_q != ST_RUN);
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_FILL;
          relatch = 1'b1;
        end
      end
      ST_FILL: begin
        if (!enable) begin
          if (!busy) state_d = ST_IDLE;
        end else if (fill_done) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          if (!busy) state_d = ST_IDLE;
        end else if (dly_clamp != dly_q) begin
          state_d = ST_FILL;
          relatch = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      seq_p    <= '0;
      mute_q   <= 1'b1;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      dly_q    <= {{(ADDR_W-1){1'b0}}, 1'b1};
      ovr_q    <= 1'b0;
    end else begin
      // tick (T) -> read (T+1) -> load (T+2) -> write (T+3) -> DAC (T+4)
      seq_p <= {seq_p[PH_OUT-1:PH_RD], accept};
      if (accept) mute_q <= (state_q != ST_RUN);
      if (seq_p[PH_WR]) wr_ptr <= wr_ptr + 1'b1;
      if (relatch) begin
        dly_q    <= dly_clamp;
        fill_cnt <= '0;
      end else if (seq_p[PH_WR] && mute_q) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
      if (drop)         ovr_q <= 1'b1;
      else if (clr_ovr) ovr_q <= 1'b0;
    end
  end

  assign ram_re     = seq_p[PH_RD];
  assign fb_load    = seq_p[PH_LD];
  assign ram_we     = seq_p[PH_WR];
  assign dac_strobe = seq_p[PH_OUT];
  assign ram_rdaddr = wr_ptr - dly_q;
  assign ram_wraddr = wr_ptr;
  assign state      = state_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_echo_ctrl.sv
// tb_echo_ctrl -- randomized and directed bench for echo_ctrl with a
// transaction-level reference model (mode, write pointer, delay, fill count).
module tb_echo_ctrl;

  localparam int AW = 13;

  logic          sysclk = 1'b0;
  logic          rst = 1'b1;
  logic          data_valid = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] delay_len = '0;
  logic          clr_ovr = 1'b0;
  logic          ram_re, ram_we, fb_load, fb_mute, dac_strobe, overrun;
  logic [AW-1:0] ram_rdaddr, ram_wraddr;
  logic [1:0]    state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 = idle, 1 = filling, 2 = running
  int            m_mode = 0;
  logic [AW-1:0] m_wp   = '0;
  logic [AW-1:0] m_dly  = 13'd1;
  int            m_fill = 0;

  echo_ctrl #(.ADDR_W(AW)) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .data_valid (data_valid),
    .enable     (enable),
    .delay_len  (delay_len),
    .clr_ovr    (clr_ovr),
    .ram_re     (ram_re),
    .ram_rdaddr (ram_rdaddr),
    .ram_we     (ram_we),
    .ram_wraddr (ram_wraddr),
    .fb_load    (fb_load),
    .fb_mute    (fb_mute),
    .dac_strobe (dac_strobe),
    .state      (state),
    .overrun    (overrun)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] clampd(input logic [AW-1:0] d);
    return (d == '0) ? 13'd1 : d;
  endfunction

  // A running echo whose requested delay differs refills with the new delay.
  task automatic m_norm();
    if (m_mode == 2 && enable && clampd(delay_len) != m_dly) begin
      m_mode = 1;
      m_dly  = clampd(delay_len);
      m_fill = 0;
    end
  endtask

  task automatic m_accept(input logic muted);
    m_wp = m_wp + 1'b1;
    if (muted) begin
      m_fill++;
      if (m_fill == int'(m_dly)) m_mode = 2;
    end
    m_norm();
  endtask

  task automatic set_delay(input logic [AW-1:0] d);
    delay_len = d;
    m_norm();
  endtask

  task automatic set_enable(input bit e);
    if (e && !enable) begin
      enable = 1'b1;
      m_mode = 1;
      m_dly  = clampd(delay_len);
      m_fill = 0;
    end else if (!e) begin
      enable = 1'b0;
      m_mode = 0;
    end
  endtask

  // One sample tick followed by gap-1 further cycles (gap >= 5).
  task automatic send_tick(input int gap);
    logic          acc, emute;
    logic [AW-1:0] erd, ewr;
    logic [3:0]    ev;
    @(posedge sysclk); #1;
    data_valid = 1'b1;
    acc   = (m_mode != 0);
    emute = (m_mode != 2);
    erd   = m_wp - m_dly;
    ewr   = m_wp;
    for (int k = 1; k <= 4; k++) begin
      @(posedge sysclk); #1;
      if (k == 1) begin
        data_valid = 1'b0;
        check("state", {30'd0, state}, m_mode);
      end
      ev = acc ? (4'b0001 << (k - 1)) : 4'b0000;
      check("strobes", {28'd0, dac_strobe, ram_we, fb_load, ram_re}, {28'd0, ev});
      check("fb_mute", {31'd0, fb_mute}, {31'd0, emute});
      check("overrun", {31'd0, overrun}, 32'd0);
      if (acc && k == 1) check("rdaddr", {19'd0, ram_rdaddr}, {19'd0, erd});
      if (acc && k == 3) check("wraddr", {19'd0, ram_wraddr}, {19'd0, ewr});
    end
    if (acc) m_accept(emute);
    repeat (gap - 5) begin @(posedge sysclk); #1; end
  endtask

  // Accepted tick at c0, second tick at c3 that must be dropped.
  task automatic overrun_pair(input bit clr_same);
    logic       emute;
    logic [3:0] ev;
    emute = (m_mode != 2);
    @(posedge sysclk); #1;
    data_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge sysclk); #1;
      ev = (k <= 4) ? (4'b0001 << (k - 1)) : 4'b0000;
      check("ovr_strobes", {28'd0, dac_strobe, ram_we, fb_load, ram_re}, {28'd0, ev});
      if (k == 1) data_valid = 1'b0;
      if (k == 3) begin data_valid = 1'b1; clr_ovr = clr_same; end
      if (k == 4) begin
        data_valid = 1'b0;
        clr_ovr    = 1'b0;
        check("ovr_set", {31'd0, overrun}, 32'd1);
      end
    end
    m_accept(emute);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);
    clr_ovr = 1'b1;
    @(posedge sysclk); #1;
    clr_ovr = 1'b0;
    check("ovr_clr", {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge sysclk);
    #1;
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_strobes", {28'd0, dac_strobe, ram_we, fb_load, ram_re}, 32'd0);
    check("rst_mute", {31'd0, fb_mute}, 32'd1);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_wraddr", {19'd0, ram_wraddr}, 32'd0);
    rst = 1'b0;

    // Delay 3: three muted fills, then feedback from address 0
    delay_len = 13'd3;
    set_enable(1'b1);
    repeat (2) @(posedge sysclk);
    #1;
    for (int i = 0; i < 5; i++) send_tick(10);

    // Delay change 3 -> 5 while running
    set_delay(13'd5);
    for (int i = 0; i < 7; i++) send_tick(10);

    // Delay 0 behaves as 1
    set_delay(13'd0);
    for (int i = 0; i < 3; i++) send_tick(5);

    // Overrun: plain, then with clear in the same cycle as the drop
    overrun_pair(1'b0);
    overrun_pair(1'b1);
    send_tick(5);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0:       set_delay(AW'($urandom_range(0, 6)));
        1:       set_enable(!enable);
        default: ;
      endcase
      send_tick($urandom_range(5, 8));
    end

    // Pointer wrap with delay 2
    set_delay(13'd2);
    if (!enable) set_enable(1'b1);
    while (m_wp != 13'd8191) send_tick(5);
    send_tick(5);
    send_tick(5);

    // Reset mid-sequence with data_valid held high through release
    @(posedge sysclk); #1;
    data_valid = 1'b1;
    @(posedge sysclk); #1;
    check("pre_rst_re", {31'd0, ram_re}, 32'd1);
    @(posedge sysclk); #1;
    rst = 1'b1;
    #1;
    check("arst_strobes", {28'd0, dac_strobe, ram_we, fb_load, ram_re}, 32'd0);
    check("arst_state", {30'd0, state}, 32'd0);
    check("arst_mute", {31'd0, fb_mute}, 32'd1);
    check("arst_ovr", {31'd0, overrun}, 32'd0);
    check("arst_wraddr", {19'd0, ram_wraddr}, 32'd0);
    check("arst_rdaddr", {19'd0, ram_rdaddr}, 32'd8191);
    repeat (3) begin
      @(posedge sysclk); #1;
      check("rst_hold", {28'd0, dac_strobe, ram_we, fb_load, ram_re}, 32'd0);
    end
    rst    = 1'b0;
    m_mode = 1;
    m_wp   = '0;
    m_dly  = clampd(delay_len);
    m_fill = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge sysclk); #1;
      check("no_tick_rel", {28'd0, dac_strobe, ram_we, fb_load, ram_re}, 32'd0);
    end
    data_valid = 1'b0;
    @(posedge sysclk); #1;
    send_tick(5);
    send_tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
